// File: rtl/hex_scan_display.sv
// hex_scan_display
//   Time-multiplexed hex driver for common-anode 7-segment banks.
//   One digit is enabled for SCAN_DIV clocks, then the scan moves on.
//   New values wait in a pending buffer and reach the display register
//   only at a frame boundary, so a frame never mixes old and new digits.
//   Optional feature macro: LZ_BLANK_EN (leading-zero blanking).
//
//   load/value: a single-cycle strobe, sampled on every rising edge.
//   There is no back-pressure. A load that lands on the boundary cycle
//   goes straight to the display register. Any other load overwrites the
//   pending buffer.
module hex_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [6:0]            HEX_SEG,
  output logic [DIGITS-1:0]     HEX_AN,
  output logic                  frame_tick,
  output logic                  committed
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]       r_pre;
  logic [IW-1:0]       r_idx;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend_v;
  logic                r_pend;

  logic       w_wrap;
  logic       w_boundary;
  logic [3:0] w_nib;
  logic [6:0] w_glyph;
  logic       w_blank;

  assign w_wrap     = (r_pre == PRE_LAST);
  assign w_boundary = w_wrap && (r_idx == IDX_LAST);

  // Prescaler and digit index: the index advances once per SCAN_DIV clocks
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  // Double buffering: loads are parked in pending and committed at the frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp     <= '0;
      r_pend_v   <= '0;
      r_pend     <= 1'b0;
      committed  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      committed  <= 1'b0;
      frame_tick <= w_boundary;
      if (w_boundary) begin
        if (load) begin
          r_disp    <= value;
          r_pend    <= 1'b0;
          committed <= 1'b1;
        end else if (r_pend) begin
          r_disp    <= r_pend_v;
          r_pend    <= 1'b0;
          committed <= 1'b1;
        end
      end else if (load) begin
        r_pend_v <= value;
        r_pend   <= 1'b1;
      end
    end
  end

  // Pick the nibble for the digit currently being scanned
  always_comb begin
    w_nib = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) w_nib = r_disp[k*4 +: 4];
    end
  end

  // Blank digits above the most significant nonzero nibble; digit 0 is never blanked
`ifdef LZ_BLANK_EN
  logic [IW-1:0] w_msnz;
  always_comb begin
    w_msnz = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_disp[k*4 +: 4] != 4'h0) w_msnz = IW'(k);
    end
    w_blank = (r_idx > w_msnz);
  end
`else
  assign w_blank = 1'b0;
`endif

  // Active-low glyph ROM, bit0 = a .. bit6 = g
  always_comb begin
    w_glyph = 7'h7F;
    case (w_nib)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  // Registered pins: the enable and segments follow the index one clock later
  always_ff @(posedge clk) begin
    if (reset) begin
      HEX_SEG <= 7'h7F;
      HEX_AN  <= '1;
    end else begin
      HEX_SEG <= w_blank ? 7'h7F : w_glyph;
      HEX_AN  <= ~(DIGITS'(1) << r_idx);
    end
  end

endmodule
